// File: rtl/video_capture_fifo.sv
// Frame-capture unit: after start, skips SKIP_FRAMES frames, then captures CAP_FRAMES frames into a FWFT FIFO.
// Optional macro VCAP_SIG_EN enables a per-frame CRC-32 signature on sig; otherwise sig is tied to 0.
module video_capture_fifo #(
    parameter int COLOR_W     = 3,
    parameter int FIFO_DEPTH  = 16,
    parameter int SKIP_FRAMES = 250,
    parameter int CAP_FRAMES  = 50
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clock_en,
    input  logic [COLOR_W-1:0]     video_r,
    input  logic [COLOR_W-1:0]     video_g,
    input  logic [COLOR_W-1:0]     video_b,
    input  logic                   hsync_n,
    input  logic                   vsync_n,
    input  logic                   start,
    output logic [3*COLOR_W+1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            frame_count,
    output logic [15:0]            drop_count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            sig
);
    localparam int DATA_W = 3*COLOR_W + 2;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

    state_t            r_state;
    logic              r_prev_vsync_n;
    logic [15:0]       r_frame_count;
    logic [15:0]       r_cap_count;
    logic [15:0]       r_drop_count;
    logic              r_overflow;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_edge, w_skip_hit, w_cap_last, w_term, w_push, w_pop;
    logic w_full, w_wr_en, w_drop, w_arm;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_edge     = clock_en & r_prev_vsync_n & ~vsync_n;
    assign w_skip_hit = (32'(sat_inc16(r_frame_count)) == 32'(SKIP_FRAMES));
    assign w_cap_last = ((32'(r_cap_count) + 32'd1) == 32'(CAP_FRAMES));
    assign w_term     = (r_state == S_CAPTURE) & w_edge & w_cap_last;
    // The skip-completing edge starts the capture window, so its own sample is kept.
    assign w_push     = clock_en & (((r_state == S_SKIP) & w_edge & w_skip_hit) |
                                    ((r_state == S_CAPTURE) & ~w_term));
    assign w_pop      = out_valid & out_ready;
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_wr_en    = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & ~w_wr_en;
    assign w_arm      = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_prev_vsync_n <= 1'b1;
            r_frame_count  <= '0;
            r_cap_count    <= '0;
            r_drop_count   <= '0;
            r_overflow     <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
        end else begin
            if (clock_en) r_prev_vsync_n <= vsync_n;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr_en) - CW'(w_pop);
            if (w_drop) begin
                r_drop_count <= sat_inc16(r_drop_count);
                r_overflow   <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_arm) begin
                        r_frame_count <= '0;
                        r_cap_count   <= '0;
                        r_drop_count  <= '0;
                        r_overflow    <= 1'b0;
                        r_state       <= (SKIP_FRAMES == 0) ? S_CAPTURE : S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (w_edge) begin
                        r_frame_count <= sat_inc16(r_frame_count);
                        if (w_skip_hit) r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_edge) begin
                        r_frame_count <= sat_inc16(r_frame_count);
                        r_cap_count   <= sat_inc16(r_cap_count);
                        if (w_cap_last) r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= {video_r, video_g, video_b, hsync_n, vsync_n};
    end

    assign out_valid   = (r_count != '0);
    assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
    assign overflow    = r_overflow;
    assign busy        = (r_state == S_SKIP) | (r_state == S_CAPTURE);
    assign done        = (r_state == S_DONE) & ~out_valid;

`ifdef VCAP_SIG_EN
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    logic [31:0] r_crc;
    logic [31:0] r_sig;
    logic [31:0] w_sample_word;
    logic        w_cap_edge;

    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in, input logic [31:0] word);
        logic [31:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            c = (c[31] ^ word[i]) ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign w_sample_word = 32'({video_r, video_g, video_b});
    assign w_cap_edge    = (r_state == S_CAPTURE) & w_edge;

    // A capture edge closes the running frame; its own sample seeds the next frame's CRC.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_crc <= CRC_INIT;
            r_sig <= '0;
        end else if (w_arm) begin
            r_crc <= CRC_INIT;
            r_sig <= '0;
        end else begin
            if (w_cap_edge) r_sig <= r_crc;
            if (w_push) r_crc <= crc32_word(w_cap_edge ? CRC_INIT : r_crc, w_sample_word);
            else if (w_cap_edge) r_crc <= CRC_INIT;
        end
    end

    assign sig = r_sig;
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_video_capture_fifo.sv
// Bench for video_capture_fifo: two instances (skip/capture window, and a shallow FIFO with no skip)
// checked against a frame-level reference model and a software CRC-32.
module tb_video_capture_fifo;
    typedef logic [10:0] word_t;
    localparam int A_SKIP = 2;
    localparam int A_CAP  = 1;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ce, hs, vs, start_a, start_b, rdy_a, rdy_b;
    logic [2:0] vid_r, vid_g, vid_b;
    logic [10:0] a_data, b_data;
    logic a_valid, a_ovf, a_busy, a_done, b_valid, b_ovf, b_busy, b_done;
    logic [15:0] a_fc, a_dc, b_fc, b_dc;
    logic [31:0] a_sig, b_sig;

    int n_tests = 0;
    int n_fail  = 0;
    word_t exp_q[$];
    word_t got_a[$];
    word_t got_b[$];
    logic prev_vs;
    int e_cnt;
    logic [31:0] crc_m;

    video_capture_fifo #(.COLOR_W(3), .FIFO_DEPTH(16), .SKIP_FRAMES(A_SKIP), .CAP_FRAMES(A_CAP)) u_a (
        .clock(clk), .reset(rst), .clock_en(ce), .video_r(vid_r), .video_g(vid_g), .video_b(vid_b),
        .hsync_n(hs), .vsync_n(vs), .start(start_a), .out_data(a_data), .out_valid(a_valid),
        .out_ready(rdy_a), .frame_count(a_fc), .drop_count(a_dc), .overflow(a_ovf),
        .busy(a_busy), .done(a_done), .sig(a_sig));

    video_capture_fifo #(.COLOR_W(3), .FIFO_DEPTH(4), .SKIP_FRAMES(0), .CAP_FRAMES(2)) u_b (
        .clock(clk), .reset(rst), .clock_en(ce), .video_r(vid_r), .video_g(vid_g), .video_b(vid_b),
        .hsync_n(hs), .vsync_n(vs), .start(start_b), .out_data(b_data), .out_valid(b_valid),
        .out_ready(rdy_b), .frame_count(b_fc), .drop_count(b_dc), .overflow(b_ovf),
        .busy(b_busy), .done(b_done), .sig(b_sig));

    always @(negedge clk) begin
        if (a_valid && rdy_a) got_a.push_back(a_data);
        if (b_valid && rdy_b) got_b.push_back(b_data);
    end

    function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            crc = crc ^ {w[8*k +: 8], 24'h0};
            for (int j = 0; j < 8; j++) crc = crc[31] ? ((crc << 1) ^ POLY) : (crc << 1);
        end
        return crc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        hs = 1'b1; vs = 1'b1; vid_r = '0; vid_g = '0; vid_b = '0;
        tick(); tick();
        rst = 1'b0;
        prev_vs = 1'b1; e_cnt = 0; crc_m = 32'hFFFFFFFF;
        exp_q.delete(); got_a.delete(); got_b.delete();
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        e_cnt = 0; crc_m = 32'hFFFFFFFF;
    endtask

    function automatic logic rnd_rdy_a();
        return ($urandom_range(0, 3) != 0) || ((exp_q.size() - got_a.size()) >= 8);
    endfunction

    task automatic drive_word(input word_t w);
        {vid_r, vid_g, vid_b, hs, vs} = w;
        ce = 1'b1; tick(); ce = 1'b0;
    endtask

    // Sample is captured iff the number of frame edges since arm (incl. this sample) lies in [SKIP, SKIP+CAP).
    task automatic run_frames_a(input int nfr, input int lmin, input int lmax, input bit zero_rgb);
        for (int f = 0; f < nfr; f++) begin
            int len;
            len = $urandom_range(lmin, lmax);
            for (int s = 0; s < len; s++) begin
                logic [2:0] r, g, b;
                logic h, v;
                r = zero_rgb ? 3'd0 : 3'($urandom);
                g = zero_rgb ? 3'd0 : 3'($urandom);
                b = zero_rgb ? 3'd0 : 3'($urandom);
                h = 1'($urandom);
                v = (s == 0) ? 1'b0 : 1'b1;
                if (prev_vs && !v) e_cnt++;
                prev_vs = v;
                if (e_cnt >= A_SKIP && e_cnt < A_SKIP + A_CAP) begin
                    exp_q.push_back({r, g, b, h, v});
                    crc_m = crc_ref(crc_m, {23'b0, r, g, b});
                end
                rdy_a = rnd_rdy_a();
                drive_word({r, g, b, h, v});
                repeat ($urandom_range(0, 2)) begin
                    rdy_a = rnd_rdy_a();
                    tick();
                end
            end
        end
    endtask

    task automatic drain_a();
        ce = 1'b0; rdy_a = 1'b1;
        repeat (24) tick();
        rdy_a = 1'b0;
    endtask

    task automatic check_stream_a(input string name);
        n_tests++;
        if (got_a.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d pops, expected %0d", name, got_a.size(), exp_q.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_a[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; tick();
        n_tests++;
        if ({a_valid, a_ovf, a_busy, a_done, b_valid, b_busy, b_done} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0", {a_valid, a_ovf, a_busy, a_done, b_valid, b_busy, b_done});
        end
        n_tests++;
        if ({a_fc, a_dc, b_fc, b_dc} !== 64'd0) begin
            n_fail++; $display("FAIL reset_counts: got %h expected 0", {a_fc, a_dc, b_fc, b_dc});
        end
        n_tests++;
        if ({a_sig, a_data} !== 43'd0) begin
            n_fail++; $display("FAIL reset_sig_data: got %h expected 0", {a_sig, a_data});
        end
        rst = 1'b0;
    endtask

    task automatic test_capture_window();
        logic [31:0] exp_sig;
        do_reset();
        pulse_start_a();
        n_tests++;
        if (a_busy !== 1'b1 || a_fc !== 16'd0) begin
            n_fail++; $display("FAIL arm_busy: got busy=%b fc=%0d expected busy=1 fc=0", a_busy, a_fc);
        end
        run_frames_a(4, 8, 8, 1'b0);
        drain_a();
        n_tests++;
        if (a_fc !== 16'd3) begin n_fail++; $display("FAIL window_frame_count: got %0d expected 3", a_fc); end
        n_tests++;
        if (got_a.size() !== 8) begin n_fail++; $display("FAIL window_pushes: got %0d expected 8", got_a.size()); end
        check_stream_a("window");
        n_tests++;
        if ({a_done, a_busy, a_ovf} !== 3'b100 || a_dc !== 16'd0) begin
            n_fail++; $display("FAIL window_status: got done/busy/ovf=%b drops=%0d expected 100 drops=0", {a_done, a_busy, a_ovf}, a_dc);
        end
`ifdef VCAP_SIG_EN
        exp_sig = crc_m;
`else
        exp_sig = 32'd0;
`endif
        n_tests++;
        if (a_sig !== exp_sig) begin n_fail++; $display("FAIL window_sig: got %h expected %h", a_sig, exp_sig); end
    endtask

    task automatic test_random_rearm();
        logic [31:0] exp_sig;
        for (int it = 0; it < 3; it++) begin
            exp_q.delete(); got_a.delete();
            pulse_start_a();
            n_tests++;
            if (a_fc !== 16'd0 || a_busy !== 1'b1) begin
                n_fail++; $display("FAIL rearm_clear: got fc=%0d busy=%b expected fc=0 busy=1", a_fc, a_busy);
            end
            run_frames_a($urandom_range(4, 6), 2, 9, 1'b0);
            drain_a();
            n_tests++;
            if (a_fc !== 16'((e_cnt < A_SKIP + A_CAP) ? e_cnt : A_SKIP + A_CAP)) begin
                n_fail++; $display("FAIL rearm_frame_count: got %0d expected %0d", a_fc, A_SKIP + A_CAP);
            end
            check_stream_a("rearm");
            n_tests++;
            if (a_done !== 1'b1) begin n_fail++; $display("FAIL rearm_done: got %b expected 1", a_done); end
`ifdef VCAP_SIG_EN
            exp_sig = crc_m;
`else
            exp_sig = 32'd0;
`endif
            n_tests++;
            if (a_sig !== exp_sig) begin n_fail++; $display("FAIL rearm_sig: got %h expected %h", a_sig, exp_sig); end
        end
    endtask

    task automatic test_start_ignored_reset();
        do_reset();
        pulse_start_a();
        run_frames_a(1, 8, 8, 1'b0);
        pulse_start_a();
        e_cnt = 1;
        n_tests++;
        if (a_fc !== 16'd1 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL skip_start_ignored: got fc=%0d busy=%b expected fc=1 busy=1", a_fc, a_busy);
        end
        run_frames_a(1, 8, 8, 1'b0);
        rdy_a = 1'b0;
        repeat (3) drive_word({9'($urandom), 1'b1, 1'b1});
        n_tests++;
        if (a_fc !== 16'd2 || a_valid !== 1'b1) begin
            n_fail++; $display("FAIL capture_state: got fc=%0d valid=%b expected fc=2 valid=1", a_fc, a_valid);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if ({a_busy, a_valid} !== 2'b00 || a_fc !== 16'd0) begin
            n_fail++; $display("FAIL midcap_reset: got busy=%b valid=%b fc=%0d expected 0 0 0", a_busy, a_valid, a_fc);
        end
    endtask

    task automatic test_overflow();
        word_t smp[8];
        do_reset();
        for (int i = 0; i < 8; i++) smp[i] = {10'($urandom), 1'b1};
        start_b = 1'b1; tick(); start_b = 1'b0;
        drive_word(smp[0]);
        n_tests++;
        if (b_valid !== 1'b1 || b_data !== smp[0]) begin
            n_fail++; $display("FAIL noskip_first_push: got valid=%b data=%h expected 1 %h", b_valid, b_data, smp[0]);
        end
        for (int i = 1; i < 8; i++) drive_word(smp[i]);
        tick();
        n_tests++;
        if (b_dc !== 16'd4 || b_ovf !== 1'b1 || b_valid !== 1'b1) begin
            n_fail++; $display("FAIL overflow_counts: got drops=%0d ovf=%b valid=%b expected 4 1 1", b_dc, b_ovf, b_valid);
        end
        rdy_b = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (b_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_drain_valid: got %b expected 0", b_valid); end
        rdy_b = 1'b0;
        n_tests++;
        if (got_b.size() !== 4) begin n_fail++; $display("FAIL overflow_pops: got %0d expected 4", got_b.size()); end
        for (int i = 0; i < got_b.size() && i < 4; i++) begin
            n_tests++;
            if (got_b[i] !== smp[i]) begin n_fail++; $display("FAIL overflow_order[%0d]: got %h expected %h", i, got_b[i], smp[i]); end
        end
    endtask

    task automatic test_full_push_pop();
        word_t smp[5];
        word_t w;
        got_b.delete();
        for (int i = 0; i < 5; i++) smp[i] = {10'($urandom), 1'b1};
        for (int i = 0; i < 4; i++) drive_word(smp[i]);
        rdy_b = 1'b1;
        drive_word(smp[4]);
        rdy_b = 1'b0;
        n_tests++;
        if (b_dc !== 16'd4 || b_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_pushpop_drops: got drops=%0d valid=%b expected 4 1", b_dc, b_valid);
        end
        rdy_b = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (b_valid !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_count: got valid=%b expected 0 after 4 pops", b_valid); end
        n_tests++;
        if (got_b.size() !== 5) begin n_fail++; $display("FAIL full_pushpop_pops: got %0d expected 5", got_b.size()); end
        for (int i = 0; i < got_b.size() && i < 5; i++) begin
            n_tests++;
            if (got_b[i] !== smp[i]) begin n_fail++; $display("FAIL full_pushpop_order[%0d]: got %h expected %h", i, got_b[i], smp[i]); end
        end
        drive_word({10'($urandom), 1'b0});
        drive_word({10'($urandom), 1'b1});
        drive_word({10'($urandom), 1'b0});
        repeat (4) tick();
        n_tests++;
        if (b_fc !== 16'd2 || {b_done, b_busy} !== 2'b10) begin
            n_fail++; $display("FAIL noskip_done: got fc=%0d done/busy=%b expected 2 10", b_fc, {b_done, b_busy});
        end
        rdy_b = 1'b0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        n_tests++;
        if ({b_fc, b_dc} !== 32'd0 || b_ovf !== 1'b0 || b_busy !== 1'b1) begin
            n_fail++; $display("FAIL done_rearm: got fc=%0d drops=%0d ovf=%b busy=%b expected 0 0 0 1", b_fc, b_dc, b_ovf, b_busy);
        end
        w = {10'($urandom), 1'b1};
        drive_word(w);
        n_tests++;
        if (b_valid !== 1'b1 || b_data !== w) begin
            n_fail++; $display("FAIL rearm_push: got valid=%b data=%h expected 1 %h", b_valid, b_data, w);
        end
    endtask

    task automatic test_sig_zero();
        logic [31:0] exp_sig;
        do_reset();
        pulse_start_a();
        run_frames_a(4, 8, 8, 1'b1);
        drain_a();
`ifdef VCAP_SIG_EN
        exp_sig = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) exp_sig = crc_ref(exp_sig, 32'd0);
`else
        exp_sig = 32'd0;
`endif
        n_tests++;
        if (a_sig !== exp_sig) begin n_fail++; $display("FAIL sig_zero: got %h expected %h", a_sig, exp_sig); end
        n_tests++;
        if (got_a.size() !== 8) begin n_fail++; $display("FAIL sig_zero_pushes: got %0d expected 8", got_a.size()); end
    endtask

    initial begin
        test_reset();
        test_capture_window();
        test_random_rearm();
        test_start_ignored_reset();
        test_overflow();
        test_full_push_pop();
        test_sig_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/video_capture_fifo.md
Name: video_capture_fifo

Overview:
- Synthesizable frame-capture unit on the VCE output (RGB + HSYNC_n/VSYNC_n), sampled on the pixel clock_en.
- Skips a parametrised number of frames, then captures a parametrised number of frames into a FIFO with a valid/ready drain port.
- Generalises the frame-counting/logging done in the full-system bench: colour width, FIFO depth and window are parameters; adds back-pressure, overflow accounting and an optional per-frame signature.

Parameters:
- COLOR_W, 3, bits per colour channel.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- SKIP_FRAMES, 250, frames ignored after arm; 0 allowed.
- CAP_FRAMES, 50, frames captured; must be >= 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clock_en  in  1  pixel-sample enable; inputs are only sampled when high.
- video_r / video_g / video_b  in  COLOR_W each  pixel colour.
- hsync_n, vsync_n  in  1  active-low syncs.
- start  in  1  single-cycle arm pulse.
- out_data  out  3*COLOR_W+2  {r,g,b,hsync_n,vsync_n}.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts.
- frame_count  out  16  vsync falling edges since arm; saturates at 16'hFFFF.
- drop_count  out  16  samples dropped on full; saturating.
- overflow  out  1  sticky; set on any drop.
- busy  out  1  state is SKIP or CAPTURE.
- done  out  1  state is DONE and FIFO empty.
- sig  out  32  last completed frame signature.

Behaviour:
- Reset (synchronous, active-high, clock is the only clock):
  - All outputs 0, FIFO emptied, state IDLE.
  - Reset mid-capture discards all FIFO contents.
- Frame edge:
  - vsync_n is registered only on clock_en samples.
  - edge = clock_en & prev_vsync_n & ~vsync_n.
  - prev_vsync_n resets to 1.
- States:
  - IDLE: start -> clear frame_count, drop_count, overflow, sig; go SKIP, or CAPTURE if SKIP_FRAMES==0. The FIFO is not cleared, so any undrained data remains.
  - SKIP: each edge increments frame_count. On the edge that makes frame_count==SKIP_FRAMES, go CAPTURE. That edge's sample is the first captured sample.
  - CAPTURE:
    - Every clock_en sample is pushed.
    - Each edge increments frame_count and a capture counter.
    - On the edge that completes CAP_FRAMES frames, go DONE; that edge's sample is not pushed.
  - DONE: no pushes. start -> re-arm exactly as from IDLE. done = FIFO empty.
  - start in SKIP or CAPTURE is ignored.
- FIFO:
  - First-word fall-through: out_valid = not empty, and out_data = head.
  - Pop when out_valid & out_ready.
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped: drop_count increments and overflow is set.
  - Pop on empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
  - Push-to-out_valid latency: 1 cycle.
- Counters saturate and never wrap.

Optional Feature:
- Macro VCAP_SIG_EN defined:
  - CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final xor) is computed over each pushed or dropped sample's RGB bits, zero-extended to 32 bits, one word per sample.
  - On each CAPTURE frame edge, sig <= CRC and CRC is reinitialised.
  - The terminating edge also latches sig.
- Macro undefined: sig tied to 0 and no CRC logic.

Test Plan:
- SKIP_FRAMES=2, CAP_FRAMES=1, 8 clock_en samples per frame, out_ready=1; start, 4 frames driven -> frame_count=3, exactly 8 pushes (first sample at the 2nd edge), done=1, overflow=0.
- FIFO_DEPTH=4, out_ready=0, 8 samples captured -> out_valid=1, 4 entries held, drop_count=4, overflow=1. Then out_ready=1 -> 4 pops in order, out_valid falls.
- Full FIFO with out_ready=1 on the same cycle as a clock_en push -> push accepted, drop_count unchanged, count stays 4.
- start pulsed during SKIP -> ignored, frame_count continues. reset asserted during CAPTURE -> next cycle: state IDLE, out_valid=0, frame_count=0.
- SKIP_FRAMES=0: start -> the next clock_en sample is pushed. start in DONE -> counters cleared and re-armed.
- VCAP_SIG_EN, constant RGB=0 for 8 samples in one frame -> sig equals the software CRC-32 of eight 32-bit zero words with the stated parameters. Without the macro, sig=0.
